// File: rtl/sprite_blit_ctrl.sv
// rtl/sprite_blit_ctrl.sv - copies a sprite ROM image into the frame buffer with colour-key and edge clipping
module sprite_blit_ctrl #(
    parameter int          SPR_W      = 29,
    parameter int          SPR_H      = 32,
    parameter int          FB_W       = 640,
    parameter int          FB_H       = 480,
    parameter logic [15:0] TRANSP_KEY = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  pos_x,
    input  logic [8:0]  pos_y,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic [18:0] fb_addr,
    output logic [15:0] fb_data
);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam logic [XW-1:0] X_LAST = XW'(SPR_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SPR_H - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, FINISH} state_t;

    state_t      state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [9:0]  idx_q, idx_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [8:0]  pos_y_q, pos_y_d;
    logic        abt_q, abt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        fb_valid_q, fb_valid_d;
    logic [18:0] fb_addr_q, fb_addr_d;
    logic [15:0] fb_data_q, fb_data_d;

    logic [10:0] sx, sy;
    logic [18:0] lin_addr;
    logic        last_px, skip_px;
    logic [XW-1:0] x_adv;
    logic [YW-1:0] y_adv;

    // Screen coordinates are one bit wider than needed so off-screen pixels never alias back on-screen.
    assign sx       = 11'(pos_x_q) + 11'(x_q);
    assign sy       = 11'(pos_y_q) + 11'(y_q);
    assign lin_addr = 19'(sy) * 19'(FB_W) + 19'(sx);
    assign last_px  = (x_q == X_LAST) && (y_q == Y_LAST);
    assign skip_px  = (rom_data == TRANSP_KEY) || (sx >= 11'(FB_W)) || (sy >= 11'(FB_H));
    assign x_adv    = (x_q == X_LAST) ? '0 : x_q + 1'b1;
    assign y_adv    = (x_q == X_LAST) ? y_q + 1'b1 : y_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        idx_d      = idx_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        abt_d      = abt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        fb_valid_d = fb_valid_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pos_x_d = pos_x;
                    pos_y_d = pos_y;
                    x_d     = '0;
                    y_d     = '0;
                    idx_d   = '0;
                    abt_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = FINISH;
                end else if (skip_px) begin
                    if (last_px) begin
                        state_d = FINISH;
                    end else begin
                        x_d   = x_adv;
                        y_d   = y_adv;
                        idx_d = idx_q + 10'd1;
                    end
                end else begin
                    fb_data_d  = rom_data;
                    fb_addr_d  = lin_addr;
                    fb_valid_d = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                // An abort here is remembered; the pending write must still complete its handshake.
                if (abort) begin
                    abt_d = 1'b1;
                end
                if (fb_ready) begin
                    fb_valid_d = 1'b0;
                    if (last_px || abort || abt_q) begin
                        state_d = FINISH;
                    end else begin
                        x_d     = x_adv;
                        y_d     = y_adv;
                        idx_d   = idx_q + 10'd1;
                        state_d = FETCH;
                    end
                end
            end
            FINISH: begin
                busy_d    = 1'b0;
                done_d    = !abt_q;
                aborted_d = abt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            idx_q      <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            abt_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            fb_valid_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            idx_q      <= idx_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            abt_q      <= abt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            fb_valid_q <= fb_valid_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign rom_addr = idx_q;
    assign fb_valid = fb_valid_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// tb/tb_sprite_blit_ctrl.sv - scoreboard bench for sprite_blit_ctrl
module tb_sprite_blit_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [8:0]  pos_y = '0;
    logic        busy, done, aborted, fb_valid;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic        fb_ready;
    logic [18:0] fb_addr;
    logic [15:0] fb_data;

    int   rom_mode = 0;
    bit   rnd_ready = 1'b0;
    logic ready_fix = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt = 0, abort_cnt = 0, wr_cnt = 0, done_cyc = 0, accept_cyc = 0;
    logic [44:0] exp_q[$];

    sprite_blit_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done), .aborted(aborted),
        .rom_addr(rom_addr), .rom_data(rom_data), .fb_valid(fb_valid), .fb_ready(fb_ready),
        .fb_addr(fb_addr), .fb_data(fb_data)
    );

    // Mode 0: fully opaque ramp. Mode 1: disc of radius 13 on a transparent background.
    function automatic logic [15:0] rom_fn(input int mode, input logic [9:0] a);
        int x, y, dx, dy;
        x  = int'(a) % 29;
        y  = int'(a) / 29;
        dx = x - 14;
        dy = y - 16;
        if (mode == 0) return {6'b0, a} ^ 16'hA5A5;
        if (dx * dx + dy * dy > 169) return 16'hFFFF;
        return 16'(int'(a) * 37 + 3);
    endfunction

    assign rom_data = rom_fn(rom_mode, rom_addr);

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            fb_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : ready_fix;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic        hold_pend = 1'b0;
    logic [18:0] h_addr;
    logic [15:0] h_data;
    logic [44:0] e;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            check("rom_addr_range", rom_addr <= 10'd927, 1);
            if (hold_pend) begin
                check("hold_valid", fb_valid, 1);
                check("hold_addr", fb_addr, h_addr);
                check("hold_data", fb_data, h_data);
            end
            if (fb_valid && fb_ready) begin
                wr_cnt++;
                check("no_transp_write", fb_data != 16'hFFFF, 1);
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_rom_addr", rom_addr, e[44:35]);
                    check("wr_fb_addr", fb_addr, e[34:16]);
                    check("wr_fb_data", fb_data, e[15:0]);
                end
            end
            hold_pend = fb_valid && !fb_ready;
            h_addr    = fb_addr;
            h_data    = fb_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (aborted) abort_cnt++;
        end
    end

    task automatic push_blit(input int px, input int py, output int n);
        int sx, sy, idx;
        logic [15:0] d;
        n = 0;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 29; x++) begin
                idx = y * 29 + x;
                d   = rom_fn(rom_mode, 10'(idx));
                sx  = px + x;
                sy  = py + y;
                if (d != 16'hFFFF && sx < 640 && sy < 480) begin
                    exp_q.push_back({10'(idx), 19'(sy * 640 + sx), d});
                    n++;
                end
            end
        end
    endtask

    task automatic do_start(input int px, input int py);
        @(posedge clk);
        #1;
        start = 1'b1;
        pos_x = 10'(px);
        pos_y = 9'(py);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (busy === 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, n < maxc, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic run_blit(input string tag, input int px, input int py, input int mode,
                            input int max_cyc, output int n_exp, output int n_wr);
        int d0, a0, w0;
        rom_mode = mode;
        d0 = done_cnt;
        a0 = abort_cnt;
        w0 = wr_cnt;
        push_blit(px, py, n_exp);
        do_start(px, py);
        check({tag, "_busy"}, busy, 1);
        wait_idle(tag, max_cyc);
        n_wr = wr_cnt - w0;
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_no_abort"}, abort_cnt - a0, 0);
    endtask

    int n_exp, n_wr, n_img, d0, a0, w0, t;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_fb_valid", fb_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_blit("opaque", 0, 0, 0, 4000, n_exp, n_wr);
        check("opaque_writes", n_wr, 928);
        check("opaque_done_latency", done_cyc - accept_cyc, 1857);

        run_blit("image", 100, 50, 1, 4000, n_img, n_wr);
        check("image_writes", n_wr, n_img);
        check("image_has_skips", n_img < 928, 1);

        run_blit("clip_620_460", 620, 460, 0, 4000, n_exp, n_wr);
        check("clip_620_460_writes", n_wr, 400);

        run_blit("clip_639_479", 639, 479, 0, 4000, n_exp, n_wr);
        check("clip_639_479_writes", n_wr, 1);

        rnd_ready = 1'b1;
        run_blit("backpressure", 100, 50, 1, 20000, n_exp, n_wr);
        check("backpressure_writes", n_wr, n_img);
        rnd_ready = 1'b0;
        ready_fix = 1'b1;

        // Start pulsed mid-blit with a different position must not disturb the sequence.
        rom_mode = 0;
        d0 = done_cnt;
        push_blit(5, 5, n_exp);
        do_start(5, 5);
        repeat (50) @(posedge clk);
        #1;
        start = 1'b1;
        pos_x = 10'd200;
        pos_y = 9'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("start_busy", 4000);
        check("start_busy_queue_empty", exp_q.size(), 0);
        check("start_busy_done", done_cnt - d0, 1);

        // Abort while a write is stalled: the write completes, then a single aborted pulse.
        ready_fix = 1'b0;
        repeat (2) @(posedge clk);
        rom_mode = 0;
        d0 = done_cnt;
        a0 = abort_cnt;
        w0 = wr_cnt;
        exp_q.push_back({10'd0, 19'(10 * 640 + 10), rom_fn(0, 10'd0)});
        do_start(10, 10);
        t = 0;
        while (fb_valid !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_wait_valid", t < 50, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_valid_held", fb_valid, 1);
        check("abort_busy_held", busy, 1);
        check("abort_no_pulse_yet", abort_cnt - a0, 0);
        ready_fix = 1'b1;
        wait_idle("abort", 100);
        check("abort_writes", wr_cnt - w0, 1);
        check("abort_queue_empty", exp_q.size(), 0);
        check("abort_pulse", abort_cnt - a0, 1);
        check("abort_no_done", done_cnt - d0, 0);

        // Reset while stalled in WRITE after some transparent pixels were skipped.
        ready_fix = 1'b0;
        repeat (2) @(posedge clk);
        rom_mode = 1;
        d0 = done_cnt;
        a0 = abort_cnt;
        do_start(0, 0);
        t = 0;
        while (fb_valid !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_wait_valid", t < 2000, 1);
        check("rstmid_rom_addr_moved", rom_addr != 10'd0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_fb_valid", fb_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_rom_addr", rom_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready_fix = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_no_abort", abort_cnt - a0, 0);
        check("rstmid_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
